regfile_scoreboard: RTL and testbench

// Parametrised integer register file for the 5-stage pipeline. It has two

---
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one writeback port,
// optional write-to-read bypass and a per-register busy-bit scoreboard.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic            rs1_use,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs2_use,
    output logic [XLEN-1:0] rd1_data,
    output logic [XLEN-1:0] rd2_data,
    output logic            rd1_busy,
    output logic            rd2_busy,
    output logic            hazard,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wb_ok;
    logic            iss_ok;
    logic            ok1;
    logic            ok2;
    logic            hit1;
    logic            hit2;

    // An address is writable when it exists and is not the hardwired zero register
    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !(ZERO_REG && (a == '0));
    endfunction

    assign wb_ok  = wb_en && writable(wb_addr);
    assign iss_ok = iss_en && writable(iss_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Clear on writeback first, then set on issue so a new producer wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wb_ok) begin
                busy[wb_addr] <= 1'b0;
            end
            if (iss_ok) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        ok1      = writable(rs1_addr);
        hit1     = BYPASS && wb_ok && (wb_addr == rs1_addr);
        rd1_data = '0;
        rd1_busy = 1'b0;
        if (ok1) begin
            rd1_data = hit1 ? wb_data : regs[rs1_addr];
            rd1_busy = hit1 ? 1'b0 : busy[rs1_addr];
        end
    end

    always_comb begin
        ok2      = writable(rs2_addr);
        hit2     = BYPASS && wb_ok && (wb_addr == rs2_addr);
        rd2_data = '0;
        rd2_busy = 1'b0;
        if (ok2) begin
            rd2_data = hit2 ? wb_data : regs[rs2_addr];
            rd2_busy = hit2 ? 1'b0 : busy[rs2_addr];
        end
    end

    assign hazard = (rs1_use & rd1_busy) | (rs2_use & rd2_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a
// non-bypassing instance share the same stimulus.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, iss_addr, wb_addr;
    logic        rs1_use, rs2_use, iss_en, wb_en, flush;
    logic [31:0] wb_data;
    logic [31:0] rd1_data, rd2_data, nb_rd1_data, nb_rd2_data;
    logic        rd1_busy, rd2_busy, hazard, nb_rd1_busy, nb_rd2_busy, nb_hazard;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_use(rs1_use), .rs2_addr(rs2_addr), .rs2_use(rs2_use),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .hazard(hazard), .iss_en(iss_en), .iss_addr(iss_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(32), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs1_use(rs1_use), .rs2_addr(rs2_addr), .rs2_use(rs2_use),
        .rd1_data(nb_rd1_data), .rd2_data(nb_rd2_data), .rd1_busy(nb_rd1_busy),
        .rd2_busy(nb_rd2_busy), .hazard(nb_hazard), .iss_en(iss_en), .iss_addr(iss_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        iss;
        logic [4:0]  iaddr;
        logic        wb;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fl;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_hz;
        logic [31:0] e_nb1;
        logic        e_nbb1;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic iss, input logic [4:0] iaddr,
        input logic wb, input logic [4:0] waddr, input logic [31:0] wdata, input logic fl,
        input logic [31:0] e_rd1, input logic [31:0] e_rd2,
        input logic e_b1, input logic e_b2, input logic e_hz,
        input logic [31:0] e_nb1, input logic e_nbb1);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.iss = iss; v.iaddr = iaddr; v.wb = wb; v.waddr = waddr; v.wdata = wdata; v.fl = fl;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_hz = e_hz;
        v.e_nb1 = e_nb1; v.e_nbb1 = e_nbb1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1_addr = '0; rs1_use = 1'b0; rs2_addr = '0; rs2_use = 1'b0;
        iss_en = 1'b0; iss_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    endtask

    initial begin
        //                 rs1 u1 rs2 u2 iss ia  wb wa  wdata         fl  e_rd1         e_rd2         b1 b2 hz  nb1           nbb1
        vecs[0]  = mk(5,  0, 6,  0, 0, 0,  1, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0,        0);
        vecs[1]  = mk(5,  1, 6,  1, 0, 0,  0, 0,  32'h0,        0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(0,  1, 0,  1, 0, 0,  1, 0,  32'h1234,     0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
        vecs[3]  = mk(0,  1, 5,  0, 1, 0,  0, 0,  32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0,        0);
        vecs[4]  = mk(0,  1, 7,  1, 1, 7,  0, 0,  32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
        vecs[5]  = mk(7,  0, 7,  1, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 1, 1, 32'h0,        1);
        vecs[6]  = mk(7,  0, 7,  0, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 32'h0,        1);
        vecs[7]  = mk(7,  0, 7,  1, 0, 0,  1, 7,  32'h77,       0, 32'h77,       32'h77,       0, 0, 0, 32'h0,        1);
        vecs[8]  = mk(7,  1, 7,  1, 0, 0,  0, 0,  32'h0,        0, 32'h77,       32'h77,       0, 0, 0, 32'h77,       0);
        vecs[9]  = mk(9,  1, 0,  0, 1, 9,  1, 9,  32'h99,       0, 32'h99,       32'h0,        0, 0, 0, 32'h0,        0);
        vecs[10] = mk(9,  1, 0,  0, 1, 3,  0, 0,  32'h0,        0, 32'h99,       32'h0,        1, 0, 1, 32'h99,       1);
        vecs[11] = mk(3,  1, 9,  0, 1, 4,  0, 0,  32'h0,        0, 32'h0,        32'h99,       1, 1, 1, 32'h0,        1);
        vecs[12] = mk(4,  1, 3,  1, 1, 6,  0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 1, 1, 32'h0,        1);
        vecs[13] = mk(6,  1, 10, 0, 1, 8,  1, 10, 32'hAA,       1, 32'h0,        32'hAA,       1, 0, 1, 32'h0,        1);
        vecs[14] = mk(8,  1, 6,  1, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
        vecs[15] = mk(9,  1, 3,  1, 0, 0,  0, 0,  32'h0,        0, 32'h99,       32'h0,        0, 0, 0, 32'h99,       0);
        vecs[16] = mk(10, 1, 4,  1, 1, 5,  0, 0,  32'h0,        0, 32'hAA,       32'h0,        0, 0, 0, 32'hAA,       0);
        vecs[17] = mk(5,  1, 0,  0, 1, 5,  0, 0,  32'h0,        0, 32'hDEADBEEF, 32'h0,        1, 0, 1, 32'hDEADBEEF, 1);
        vecs[18] = mk(5,  1, 5,  0, 0, 0,  1, 5,  32'h55,       0, 32'h55,       32'h55,       0, 0, 0, 32'hDEADBEEF, 1);
        vecs[19] = mk(5,  1, 11, 1, 0, 0,  1, 11, 32'h11,       0, 32'h55,       32'h11,       0, 0, 0, 32'h55,       0);
        vecs[20] = mk(11, 1, 31, 1, 0, 0,  0, 0,  32'h0,        0, 32'h11,       32'h0,        0, 0, 0, 32'h11,       0);

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Every address reads zero and idle right after reset
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rs1_use = 1'b1; rs2_use = 1'b1;
            #1;
            chk($sformatf("reset rd1_data[%0d]", i), rd1_data, 32'h0);
            chk($sformatf("reset rd2_data[%0d]", 31 - i), rd2_data, 32'h0);
            chk($sformatf("reset busy[%0d]", i), 32'({rd1_busy, rd2_busy}), 32'h0);
            chk($sformatf("reset hazard[%0d]", i), 32'(hazard), 32'h0);
        end
        idle();

        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            rs1_addr = vecs[k].rs1; rs1_use = vecs[k].u1;
            rs2_addr = vecs[k].rs2; rs2_use = vecs[k].u2;
            iss_en = vecs[k].iss; iss_addr = vecs[k].iaddr;
            wb_en = vecs[k].wb; wb_addr = vecs[k].waddr; wb_data = vecs[k].wdata;
            flush = vecs[k].fl;
            #1;
            chk($sformatf("v%0d rd1_data", k), rd1_data, vecs[k].e_rd1);
            chk($sformatf("v%0d rd2_data", k), rd2_data, vecs[k].e_rd2);
            chk($sformatf("v%0d rd1_busy", k), 32'(rd1_busy), 32'(vecs[k].e_b1));
            chk($sformatf("v%0d rd2_busy", k), 32'(rd2_busy), 32'(vecs[k].e_b2));
            chk($sformatf("v%0d hazard", k), 32'(hazard), 32'(vecs[k].e_hz));
            chk($sformatf("v%0d nobypass rd1_data", k), nb_rd1_data, vecs[k].e_nb1);
            chk($sformatf("v%0d nobypass rd1_busy", k), 32'(nb_rd1_busy), 32'(vecs[k].e_nbb1));
        end

        // Mark reg 13 busy, then reset mid-run with a coincident writeback to reg 12
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_addr = 5'd13;
        @(negedge clk);
        idle();
        rs1_addr = 5'd13; rs1_use = 1'b1; rs2_addr = 5'd7; rs2_use = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0C0C0C0;
        #1;
        chk("pre-reset busy13", 32'(rd1_busy), 32'h1);
        chk("pre-reset hazard", 32'(hazard), 32'h1);
        chk("pre-reset rd2 reg7", rd2_data, 32'h77);
        rst_n = 1'b0;
        #1;
        chk("async reset busy13", 32'(rd1_busy), 32'h0);
        chk("async reset hazard", 32'(hazard), 32'h0);
        chk("async reset rd2 reg7", rd2_data, 32'h0);
        chk("async reset nobypass rd2", nb_rd2_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        rs1_addr = 5'd12; rs2_addr = 5'd5;
        #1;
        chk("wb during reset lost", rd1_data, 32'h0);
        chk("reg5 cleared by reset", rd2_data, 32'h0);
        chk("nobypass wb during reset lost", nb_rd1_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
